// File: rtl/fft_pkg.sv
// Shared types and sizes for the 16-point FFT output reorder stage.
package fft_pkg;

    localparam int unsigned DATA_W = 17;
    localparam int unsigned NPOINT = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned IDX_W  = $clog2(NPOINT);
    localparam int unsigned WCNT_W = $clog2(LANES);

    // One complex sample, Re in the upper half
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Ping-pong bank occupancy
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } bank_st_t;

endpackage

// File: rtl/p_s_bank.sv
// 16-entry complex register file: 4-lane write (word j -> bins j+4l), one indexed read.
module p_s_bank
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = fft_pkg::DATA_W,
    parameter int unsigned NPOINT = fft_pkg::NPOINT
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [WCNT_W-1:0]          widx,
    input  logic [LANES*2*DATA_W-1:0]  wdata,
    input  logic [IDX_W-1:0]           ridx,
    output logic [DATA_W-1:0]          rd_re,
    output logic [DATA_W-1:0]          rd_im
);

    localparam int unsigned LANE_W = 2 * DATA_W;

    logic [NPOINT-1:0][DATA_W-1:0] re_q, re_d;
    logic [NPOINT-1:0][DATA_W-1:0] im_q, im_d;

    // Scatter the four lanes of word j into bins {l, j}
    always_comb begin
        re_d = re_q;
        im_d = im_q;
        if (we) begin
            for (int l = 0; l < int'(LANES); l++) begin
                re_d[{WCNT_W'(l), widx}] = wdata[l*LANE_W + DATA_W +: DATA_W];
                im_d[{WCNT_W'(l), widx}] = wdata[l*LANE_W +: DATA_W];
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        re_q <= re_d;
        im_q <= im_d;
    end

    assign rd_re = re_q[ridx];
    assign rd_im = im_q[ridx];

endmodule

// File: rtl/p_s_reorder.sv
// Parallel-to-serial reorder for the 16-point radix-4 FFT: ping-pong banks,
// natural-order serial output. Optional macro P_S_SCALE_EN divides outputs by 4.
module p_s_reorder
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = fft_pkg::DATA_W,
    parameter int unsigned NPOINT = fft_pkg::NPOINT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*DATA_W-1:0]  bf_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_re,
    output logic [DATA_W-1:0]    out_im,
    output logic [IDX_W-1:0]     out_index,
    output logic                 out_last
);

    bank_st_t            state_q [2];
    bank_st_t            state_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [IDX_W-1:0]    oidx_q, oidx_d;

    logic                in_fire, out_fire, fill_done, drain_done;
    logic [1:0]          bank_we;
    logic [1:0][DATA_W-1:0] bank_re, bank_im;
    logic [DATA_W-1:0]   sel_re, sel_im, res_re, res_im;

    assign in_ready   = (state_q[wr_ptr_q] == FILL);
    assign out_valid  = (state_q[rd_ptr_q] == FULL);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign fill_done  = in_fire && (wcnt_q == WCNT_W'(LANES - 1));
    assign drain_done = out_fire && (oidx_q == IDX_W'(NPOINT - 1));

    // Two banks; only the current write bank sees the write enable
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = in_fire && (wr_ptr_q == 1'(b));

        p_s_bank #(
            .DATA_W (DATA_W),
            .NPOINT (NPOINT)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .widx  (wcnt_q),
            .wdata (bf_in),
            .ridx  (oidx_q),
            .rd_re (bank_re[b]),
            .rd_im (bank_im[b])
        );
    end

    // Bank states, pointers and counters; fill and drain act on different banks
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wcnt_d   = wcnt_q;
        oidx_d   = oidx_q;
        if (in_fire) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
        if (fill_done) begin
            state_d[wr_ptr_q] = FULL;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (out_fire) begin
            oidx_d = oidx_q + IDX_W'(1);
        end
        if (drain_done) begin
            state_d[rd_ptr_q] = FILL;
            rd_ptr_d          = ~rd_ptr_q;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= FILL;
            state_q[1] <= FILL;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wcnt_q     <= '0;
            oidx_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wcnt_q     <= wcnt_d;
            oidx_q     <= oidx_d;
        end
    end

`ifdef P_S_SCALE_EN
    // Divide by 4 with round-half-up; one guard bit keeps the +2 from overflowing
    function automatic logic [DATA_W-1:0] scale_q2(input logic [DATA_W-1:0] x);
        logic signed [DATA_W:0] t;
        logic signed [DATA_W:0] s;
        t = {x[DATA_W-1], x} + (DATA_W+1)'(2);
        s = t >>> 2;
        return s[DATA_W-1:0];
    endfunction
`endif

    // Output mux, optional scaling, and zeroing while idle
    always_comb begin
        sel_re = bank_re[rd_ptr_q];
        sel_im = bank_im[rd_ptr_q];
`ifdef P_S_SCALE_EN
        res_re = scale_q2(sel_re);
        res_im = scale_q2(sel_im);
`else
        res_re = sel_re;
        res_im = sel_im;
`endif
        out_re    = out_valid ? res_re : '0;
        out_im    = out_valid ? res_im : '0;
        out_index = out_valid ? oidx_q : '0;
        out_last  = out_valid && (oidx_q == IDX_W'(NPOINT - 1));
    end

endmodule
